// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its store buffer.
package dmem_responder_pkg;

    localparam int unsigned DMEM_WORDS_DEFAULT = 1024;
    localparam int unsigned SB_DEPTH_DEFAULT   = 4;
    // Index field covers the largest word-addressable depth; unused upper bits stay zero.
    localparam int unsigned SB_IDX_W           = 30;

    typedef struct packed {
        logic                valid;
        logic [SB_IDX_W-1:0] idx;
        logic [31:0]         data;
        logic [3:0]          be;
    } sb_entry_t;

    function automatic logic [1:0] lowest_lane(input logic [3:0] be);
        logic [1:0] lane;
        lane = 2'd0;
        if (be[0])      lane = 2'd0;
        else if (be[1]) lane = 2'd1;
        else if (be[2]) lane = 2'd2;
        else if (be[3]) lane = 2'd3;
        return lane;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the execute stage and the data-memory responder.
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEFAULT
) ();
    localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_we;
    logic          dmem_re;
    logic [31:0]   dmem_rdata;
    logic          dmem_stall;
    logic          drain_req;
    logic          drain_done;
    logic [CW-1:0] sb_count;

    modport master (
        output dmem_addr, dmem_wdata, dmem_we, dmem_re, drain_req,
        input  dmem_rdata, dmem_stall, drain_done, sb_count
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_we, dmem_re, drain_req,
        output dmem_rdata, dmem_stall, drain_done, sb_count
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: byte-enabled synchronous write, combinational read.
module dmem_ram #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic                         we,
    input  logic [3:0]                   be,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);
    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency loads, posted store buffer with
// load forwarding, draining into the word RAM on load-free cycles.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DMEM_WORDS_DEFAULT,
    parameter int unsigned SB_DEPTH  = SB_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t       entries [SB_DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic [AW-1:0]   load_idx;
    logic            full;
    logic            has_store;
    logic            stall_c;
    logic            push;
    logic            pop;
    sb_entry_t       new_entry;
    sb_entry_t       head_entry;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_rdata;
    logic [31:0]     load_word;
    logic [PW-1:0]   slot;
    logic            unused_ok;

    assign load_idx   = bus.dmem_addr[AW+1:2];
    assign full       = (count == CW'(SB_DEPTH));
    assign has_store  = (bus.dmem_we != 4'b0000);
    assign stall_c    = full && has_store && bus.dmem_re;
    assign push       = has_store && !stall_c;
    // The RAM port belongs to the load, so commits only happen on load-free cycles.
    assign pop        = (count != '0) && !bus.dmem_re;
    assign head_entry = entries[head];

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.idx   = SB_IDX_W'(load_idx);
        new_entry.data  = bus.dmem_wdata << {lowest_lane(bus.dmem_we), 3'b000};
        new_entry.be    = bus.dmem_we;
    end

    // Pop clears before push writes, so a full-buffer push/pop keeps the new entry valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < int'(SB_DEPTH); i++) entries[i].valid <= 1'b0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PW'(1);
            end
            if (push) begin
                entries[tail] <= new_entry;
                tail          <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign ram_addr = pop ? AW'(head_entry.idx) : load_idx;

    dmem_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (pop),
        .be    (head_entry.be),
        .wdata (head_entry.data),
        .rdata (ram_rdata)
    );

    // Overlay pending stores oldest to newest so the newest wins per byte lane.
    always_comb begin
        load_word = ram_rdata;
        slot      = '0;
        for (int k = 0; k < int'(SB_DEPTH); k++) begin
            slot = head + PW'(k);
            if ((CW'(k) < count) && entries[slot].valid &&
                (entries[slot].idx == SB_IDX_W'(load_idx))) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[slot].be[b]) load_word[8*b +: 8] = entries[slot].data[8*b +: 8];
                end
            end
        end
    end

    assign bus.dmem_rdata = load_word >> {bus.dmem_addr[1:0], 3'b000};
    assign bus.dmem_stall = stall_c;
    assign bus.drain_done = (count == '0);
    assign bus.sb_count   = count;

    // Fence request only gates issue upstream; high address bits alias.
    assign unused_ok = ^{bus.drain_req, bus.dmem_addr[31:AW+2]};
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    dmem_responder_if #(.SB_DEPTH(4)) bus ();

    dmem_responder #(.MEM_WORDS(1024), .SB_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] we, input logic re);
        bus.dmem_addr  = a;
        bus.dmem_wdata = d;
        bus.dmem_we    = we;
        bus.dmem_re    = re;
    endtask

    task automatic idle();
        drv(32'h0, 32'h0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.sb_count !== 3'd0) begin
            n_err++; $display("FAIL reset_count got %0d exp 0", bus.sb_count);
        end
        n_cmp++;
        if (bus.drain_done !== 1'b1) begin
            n_err++; $display("FAIL reset_drain_done got %b exp 1", bus.drain_done);
        end
        n_cmp++;
        if (bus.dmem_stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall got %b exp 0", bus.dmem_stall);
        end
    endtask

    task automatic test_sw_forward();
        drv(32'h100, 32'hDEADBEEF, 4'b1111, 1'b0);
        tick();
        n_cmp++;
        if (bus.sb_count !== 3'd1) begin
            n_err++; $display("FAIL sw_push_count got %0d exp 1", bus.sb_count);
        end
        drv(32'h100, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL sw_forward got %h exp deadbeef", bus.dmem_rdata);
        end
        tick();
        n_cmp++;
        if (bus.sb_count !== 3'd1) begin
            n_err++; $display("FAIL sw_no_commit_on_load got %0d exp 1", bus.sb_count);
        end
        idle();
        tick();
        n_cmp++;
        if (bus.sb_count !== 3'd0) begin
            n_err++; $display("FAIL sw_commit_count got %0d exp 0", bus.sb_count);
        end
        drv(32'h100, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL sw_ram_read got %h exp deadbeef", bus.dmem_rdata);
        end
        tick();
    endtask

    task automatic test_byte_merge();
        drv(32'h200, 32'h11223344, 4'b1111, 1'b0);
        tick();
        idle();
        tick();
        drv(32'h202, 32'h000000AB, 4'b0100, 1'b0);
        tick();
        drv(32'h200, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'h11AB3344) begin
            n_err++; $display("FAIL sb_merge_word got %h exp 11ab3344", bus.dmem_rdata);
        end
        drv(32'h202, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'h000011AB) begin
            n_err++; $display("FAIL sb_shift_read got %h exp 000011ab", bus.dmem_rdata);
        end
        tick();
        idle();
        tick();
        drv(32'h200, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'h11AB3344) begin
            n_err++; $display("FAIL sb_committed_word got %h exp 11ab3344", bus.dmem_rdata);
        end
        tick();
    endtask

    task automatic test_newest_wins();
        drv(32'h204, 32'hCAFE0000, 4'b1111, 1'b0);
        tick();
        idle();
        tick();
        drv(32'h204, 32'h00001111, 4'b0011, 1'b1);
        tick();
        drv(32'h204, 32'h00002222, 4'b0011, 1'b1);
        tick();
        drv(32'h204, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'hCAFE2222) begin
            n_err++; $display("FAIL sh_newest_fwd got %h exp cafe2222", bus.dmem_rdata);
        end
        idle();
        tick();
        tick();
        drv(32'h204, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'hCAFE2222) begin
            n_err++; $display("FAIL sh_newest_ram got %h exp cafe2222", bus.dmem_rdata);
        end
        tick();
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 4; i++) begin
            drv(32'h300 + 32'(4*i), 32'hA0000000 + 32'(i), 4'b1111, 1'b1);
            tick();
        end
        n_cmp++;
        if (bus.sb_count !== 3'd4) begin
            n_err++; $display("FAIL full_count got %0d exp 4", bus.sb_count);
        end
        drv(32'h310, 32'hBBBBBBBB, 4'b1111, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_stall !== 1'b1) begin
            n_err++; $display("FAIL full_stall got %b exp 1", bus.dmem_stall);
        end
        tick();
        n_cmp++;
        if (bus.sb_count !== 3'd4) begin
            n_err++; $display("FAIL full_dropped_count got %0d exp 4", bus.sb_count);
        end
        drv(32'h30C, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'hA0000003) begin
            n_err++; $display("FAIL full_fwd got %h exp a0000003", bus.dmem_rdata);
        end
        // Full buffer, store without load: head pops while the store pushes.
        drv(32'h310, 32'hCCCCCCCC, 4'b1111, 1'b0);
        #1;
        n_cmp++;
        if (bus.dmem_stall !== 1'b0) begin
            n_err++; $display("FAIL full_no_load_stall got %b exp 0", bus.dmem_stall);
        end
        tick();
        n_cmp++;
        if (bus.sb_count !== 3'd4) begin
            n_err++; $display("FAIL full_swap_count got %0d exp 4", bus.sb_count);
        end
        idle();
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.drain_done !== 1'b0 || bus.sb_count !== 3'd1) begin
            n_err++; $display("FAIL drain_3 got count %0d done %b exp 1/0", bus.sb_count, bus.drain_done);
        end
        tick();
        n_cmp++;
        if (bus.drain_done !== 1'b1 || bus.sb_count !== 3'd0) begin
            n_err++; $display("FAIL drain_4 got count %0d done %b exp 0/1", bus.sb_count, bus.drain_done);
        end
        drv(32'h310, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'hCCCCCCCC) begin
            n_err++; $display("FAIL full_swap_ram got %h exp cccccccc", bus.dmem_rdata);
        end
        drv(32'h304, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'hA0000001) begin
            n_err++; $display("FAIL full_ram_304 got %h exp a0000001", bus.dmem_rdata);
        end
        tick();
    endtask

    task automatic test_alias();
        drv(32'h0, 32'h0A0A0A0A, 4'b1111, 1'b0);
        tick();
        drv(32'h1000, 32'h0B0B0B0B, 4'b1111, 1'b0);
        tick();
        drv(32'h0, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'h0B0B0B0B) begin
            n_err++; $display("FAIL alias_fwd got %h exp 0b0b0b0b", bus.dmem_rdata);
        end
        idle();
        tick();
        drv(32'h1000, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'h0B0B0B0B) begin
            n_err++; $display("FAIL alias_ram got %h exp 0b0b0b0b", bus.dmem_rdata);
        end
        tick();
    endtask

    task automatic test_reset_discard();
        drv(32'h400, 32'h55555555, 4'b1111, 1'b0);
        tick();
        idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(32'h400, 32'h99990000 + 32'(i), 4'b1111, 1'b1);
            tick();
        end
        n_cmp++;
        if (bus.sb_count !== 3'd3) begin
            n_err++; $display("FAIL rst_pre_count got %0d exp 3", bus.sb_count);
        end
        reset = 1'b1;
        drv(32'h400, 32'h77777777, 4'b1111, 1'b1);
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.sb_count !== 3'd0 || bus.drain_done !== 1'b1) begin
            n_err++; $display("FAIL rst_discard got count %0d done %b exp 0/1", bus.sb_count, bus.drain_done);
        end
        drv(32'h400, 32'h0, 4'b0000, 1'b1);
        #1;
        n_cmp++;
        if (bus.dmem_rdata !== 32'h55555555) begin
            n_err++; $display("FAIL rst_old_ram got %h exp 55555555", bus.dmem_rdata);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.drain_req = 1'b0;
        reset = 1'b1;
        idle();
        test_reset();
        test_sw_forward();
        test_byte_merge();
        test_newest_wins();
        test_full_stall();
        test_alias();
        test_reset_discard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the load/store port driven by the memory-capable execute datapath. Presents zero-latency combinational read data and absorbs stores into a small posted store buffer that drains into a byte-enabled word RAM during read-free cycles. Loads forward from pending stores, so the buffer is invisible to software. Sits between the execute stage's `dmem_*` signals and the on-chip data RAM.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two. `AW = $clog2(MEM_WORDS)`.
- `SB_DEPTH`, 4: store-buffer entries; power of two, ≥2.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `dmem_addr`  in  32  byte address.
- `dmem_wdata`  in  32  store data, unaligned (byte/half in low bits).
- `dmem_we`  in  4  byte-lane enables, already shifted to the addressed lane; `0` means no store.
- `dmem_re`  in  1  load request.
- `dmem_rdata`  out  32  load data, right-aligned to `dmem_addr[1:0]`.
- `dmem_stall`  out  1  store refused this cycle; consumed by the hazard unit.
- `drain_req`  in  1  fence request.
- `drain_done`  out  1  buffer empty.
- `sb_count`  out  `$clog2(SB_DEPTH)+1`  valid entries.

## Operation
- Word index = `dmem_addr[AW+1:2]`; upper bits ignored, so addresses wrap modulo `4*MEM_WORDS`.
- Store alignment: `shift = 8 × index of lowest set bit of dmem_we`; entry data = `dmem_wdata << shift`; entry = {word index, aligned data, `dmem_we`}.
- Push: `dmem_we != 0` and not `dmem_stall` → entry written at tail.
- Pop/commit: when buffer non-empty and `dmem_re == 0`, the head entry is written to RAM under its byte enables and popped. A load owns the single RAM port, so no commit happens in a load cycle.
- Push and pop in the same cycle are allowed; count unchanged.
- `dmem_stall = (sb_count == SB_DEPTH) && dmem_we != 0 && dmem_re`; the store is dropped and must be re-presented. A full buffer with a store and no load still pushes, because the head pops the same cycle.
- Load word = RAM word at index, overlaid per byte lane with every valid buffer entry matching the index, oldest to newest. Newest entry wins per lane.
- `dmem_rdata = load_word >> (8 × dmem_addr[1:0])`, zero-filled. Sign/zero extension is done by the requester.
- A store and a load asserted in the same cycle: the load returns the pre-store value.
- `dmem_rdata` is defined regardless of `dmem_re`.
- `drain_done = (sb_count == 0)`. `drain_req` has no effect on drain rate; it exists so a fence can hold issue until `drain_done`.

## Timing
- Load: combinational, 0 cycles, from `dmem_addr`/`dmem_re` to `dmem_rdata`.
- Store is visible to loads from the cycle after it is pushed, via forwarding.
- Earliest RAM commit is 1 cycle after push. With no loads, N entries drain in N cycles.
- Reset values: head/tail/count = 0, all entry valid bits = 0, `sb_count` = 0, `drain_done` = 1, `dmem_stall` = 0.
- `dmem_rdata` after reset equals the RAM contents; RAM is not reset.
- Reset during pending stores discards them. Reset has priority over a push in the same cycle.
- Pointers are `$clog2(SB_DEPTH)` bits and wrap naturally; full/empty are decided by `sb_count`.

## Structure
- Shared package: `sb_entry_t` {valid, word index `[AW-1:0]`, data `[31:0]`, be `[3:0]`}, and constants `DMEM_WORDS_DEFAULT`, `SB_DEPTH_DEFAULT`.
- Sub-module `dmem_ram`: `MEM_WORDS`×32, byte-enabled synchronous write, combinational read, single address port muxed between the load index and the head commit index.
- Forwarding overlay and store-buffer control live in `dmem_responder`.

## Test plan
- SW `0x100`=`0xDEADBEEF`, next cycle LW `0x100` → `0xDEADBEEF` via forwarding. After an idle cycle it commits; LW again → same value from RAM, `sb_count`=0.
- Word `0x200` holds `0x11223344`; SB `addr=0x202`, `wdata=0x000000AB`, `we=0100`, then LW `0x200` → `0x11AB3344`. LB-style read at `0x202` → `rdata=0x000011AB`.
- SH `0x204` `we=0011` data `0x1111`, then SH `0x204` `we=0011` data `0x2222`, then LW `0x204` → low half `0x2222` (newest wins).
- Fill buffer with 4 stores while loads are asserted each cycle; 5th store arriving with `dmem_re=1` → `dmem_stall=1`, store dropped, `sb_count`=4. Drop `dmem_re` → one pop per cycle, `drain_done`=1 after 4 cycles.
- Store to `0x0` and to `4*MEM_WORDS` (aliases word 0) → the later value wins.
- Push 3 entries, assert `reset` for one cycle → `sb_count`=0, `drain_done`=1, and loads return the old RAM values.
